// File: rtl/smc_rdata_pack_lite8.sv
`default_nettype none
// ============================================================================
// Module   : smc_rdata_pack_lite8
// Purpose  : Read-data return path of the lite static memory controller.
//            Collects external-memory read beats (one per smc_sample8) and
//            assembles them into a single 32-bit AHB read word. The word is
//            presented with a one-cycle rdata_valid8 strobe.
// Ports    : sys_clk8       - system clock, rising edge
//            sys_reset8     - synchronous active-high reset
//            valid_access8  - start of a new access (latches sizes/address)
//            v_xfer_size8   - transfer size 00=8b 01=16b 10=32b 11=invalid
//            v_bus_size8    - external bus width 00=8b 01=16b 10=32b 11=invalid
//            v_addr8        - AHB address bits [1:0]
//            smc_sample8    - one read beat is valid on data_smc8
//            data_smc8      - external memory read data
//            smc_hrdata8    - assembled AHB read data (held until next word)
//            rdata_valid8   - one-cycle pulse, smc_hrdata8 complete
//            pack_busy8     - beats outstanding
// Revision : 1.0 - initial release
// ============================================================================
module smc_rdata_pack_lite8 #(
  parameter bit REPLICATE = 1'b1
) (
  input  logic        sys_clk8,
  input  logic        sys_reset8,
  input  logic        valid_access8,
  input  logic [1:0]  v_xfer_size8,
  input  logic [1:0]  v_bus_size8,
  input  logic [1:0]  v_addr8,
  input  logic        smc_sample8,
  input  logic [31:0] data_smc8,
  output logic [31:0] smc_hrdata8,
  output logic        rdata_valid8,
  output logic        pack_busy8
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  localparam logic [1:0] SZ_8   = 2'b00;
  localparam logic [1:0] SZ_16  = 2'b01;
  localparam logic [1:0] SZ_32  = 2'b10;
  localparam logic [1:0] SZ_BAD = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  xfer_q, xfer_d;
  logic [1:0]  bus_q, bus_d;
  logic [1:0]  addr_q, addr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic [31:0] beat;
  logic [31:0] acc_shift;
  logic [7:0]  res_byte;
  logic [15:0] res_half;
  logic [31:0] result;

  // Number of beats the address generator issues for a size combination.
  function automatic logic [2:0] beat_count(input logic [1:0] xfer,
                                            input logic [1:0] bus);
    logic [2:0] n;
    n = 3'd1;
    if (xfer == SZ_BAD || bus == SZ_BAD) begin
      n = 3'd1;
    end else if (xfer == SZ_32 && bus == SZ_8) begin
      n = 3'd4;
    end else if ((xfer == SZ_32 && bus == SZ_16) ||
                 (xfer == SZ_16 && bus == SZ_8)) begin
      n = 3'd2;
    end
    return n;
  endfunction

  // Lane extraction for the current beat, right-justified.
  always_comb begin
    beat = data_smc8;
    case (bus_q)
      SZ_8:  beat = {24'h0, data_smc8[7:0]};
      SZ_16: beat = {16'h0, data_smc8[15:0]};
      default: begin
        case (xfer_q)
          SZ_8: begin
            case (addr_q)
              2'b00:   beat = {24'h0, data_smc8[7:0]};
              2'b01:   beat = {24'h0, data_smc8[15:8]};
              2'b10:   beat = {24'h0, data_smc8[23:16]};
              default: beat = {24'h0, data_smc8[31:24]};
            endcase
          end
          SZ_16:   beat = addr_q[1] ? {16'h0, data_smc8[31:16]}
                                    : {16'h0, data_smc8[15:0]};
          default: beat = data_smc8;
        endcase
      end
    endcase
  end

  // Beats arrive most significant first, so each new beat is shifted in at
  // the bottom and earlier beats move up by one bus width.
  always_comb begin
    case (bus_q)
      SZ_8:    acc_shift = {acc_q[23:0], beat[7:0]};
      SZ_16:   acc_shift = {acc_q[15:0], beat[15:0]};
      default: acc_shift = beat;
    endcase
  end

  // Place the assembled datum onto the AHB byte lanes.
  always_comb begin
    res_byte = acc_shift[7:0];
    res_half = acc_shift[15:0];
    result   = acc_shift;
    if (xfer_q == SZ_BAD || bus_q == SZ_BAD) begin
      result = 32'h0;
    end else if (xfer_q == SZ_16) begin
      if (REPLICATE) begin
        result = {res_half, res_half};
      end else begin
        result = addr_q[1] ? {res_half, 16'h0} : {16'h0, res_half};
      end
    end else if (xfer_q == SZ_8) begin
      if (REPLICATE) begin
        result = {4{res_byte}};
      end else begin
        result = {24'h0, res_byte} << {addr_q, 3'b000};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    xfer_d   = xfer_q;
    bus_d    = bus_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    hrdata_d = hrdata_q;
    valid_d  = 1'b0;

    // A new access always wins: in COLLECT it aborts the partial transfer,
    // in RESP it follows the pulse, and any coincident sample is dropped.
    if (valid_access8) begin
      state_d = ST_COLLECT;
      xfer_d  = v_xfer_size8;
      bus_d   = v_bus_size8;
      addr_d  = v_addr8;
      cnt_d   = beat_count(v_xfer_size8, v_bus_size8);
      acc_d   = 32'h0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (smc_sample8 && cnt_q != 3'd0) begin
            acc_d = acc_shift;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
              state_d  = ST_RESP;
              valid_d  = 1'b1;
              hrdata_d = result;
            end
          end
        end
        ST_RESP: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_COLLECT);
  end

  always_ff @(posedge sys_clk8) begin
    if (sys_reset8) begin
      state_q  <= ST_IDLE;
      xfer_q   <= 2'b00;
      bus_q    <= 2'b00;
      addr_q   <= 2'b00;
      cnt_q    <= 3'd0;
      acc_q    <= 32'h0;
      hrdata_q <= 32'h0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xfer_q   <= xfer_d;
      bus_q    <= bus_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      hrdata_q <= hrdata_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign smc_hrdata8  = hrdata_q;
  assign rdata_valid8 = valid_q;
  assign pack_busy8   = busy_q;

endmodule
`default_nettype wire
